// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer for the riscV32I core: streams a program into instruction memory
// under core reset, flushes the pipeline, then enables the core for a bounded or stopped run.
module imem_boot_ctrl #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       run_limit,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_wen,
    output logic              core_rst,
    output logic              core_enb,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [7:0]        word_count,
    output logic [15:0]       cycle_count
);

    localparam int unsigned WC_W = 8;
    localparam int unsigned CC_W = 16;
    localparam int unsigned FL_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              s_ready_nxt, inst_wen_nxt, core_rst_nxt, core_enb_nxt;
    logic              busy_nxt, done_nxt, err_nxt;
    logic [31:0]       inst_data_nxt;
    logic [ADDR_W-1:0] inst_addr_nxt;
    logic [WC_W-1:0]   word_count_nxt;
    logic [CC_W-1:0]   cycle_count_nxt, cycle_inc;
    logic [CC_W-1:0]   limit_q, limit_nxt;
    logic [FL_W-1:0]   flush_cnt, flush_cnt_nxt;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            s_ready      <= 1'b0;
            inst_data    <= '0;
            inst_addr    <= '0;
            inst_wen     <= 1'b0;
            core_rst     <= 1'b1;
            core_enb     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
            cycle_count  <= '0;
            limit_q      <= '0;
            flush_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            s_ready      <= s_ready_nxt;
            inst_data    <= inst_data_nxt;
            inst_addr    <= inst_addr_nxt;
            inst_wen     <= inst_wen_nxt;
            core_rst     <= core_rst_nxt;
            core_enb     <= core_enb_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err_overflow <= err_nxt;
            word_count   <= word_count_nxt;
            cycle_count  <= cycle_count_nxt;
            limit_q      <= limit_nxt;
            flush_cnt    <= flush_cnt_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        s_ready_nxt     = s_ready;
        inst_data_nxt   = inst_data;
        inst_addr_nxt   = inst_addr;
        inst_wen_nxt    = 1'b0;
        core_rst_nxt    = core_rst;
        core_enb_nxt    = core_enb;
        busy_nxt        = busy;
        done_nxt        = done;
        err_nxt         = err_overflow;
        word_count_nxt  = word_count;
        cycle_count_nxt = cycle_count;
        limit_nxt       = limit_q;
        flush_cnt_nxt   = flush_cnt;
        cycle_inc       = (cycle_count == '1) ? cycle_count : cycle_count + CC_W'(1);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt       = ST_LOAD;
                    s_ready_nxt     = 1'b1;
                    core_rst_nxt    = 1'b1;
                    core_enb_nxt    = 1'b0;
                    busy_nxt        = 1'b1;
                    done_nxt        = 1'b0;
                    err_nxt         = 1'b0;
                    word_count_nxt  = '0;
                    cycle_count_nxt = '0;
                    limit_nxt       = run_limit;
                end
            end
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    inst_wen_nxt   = 1'b1;
                    inst_data_nxt  = s_data;
                    inst_addr_nxt  = ADDR_W'(word_count);
                    word_count_nxt = word_count + WC_W'(1);
                    // Memory full without s_last: truncate instead of wrapping
                    if (s_last || (word_count == WC_W'(DEPTH - 1))) begin
                        state_nxt     = ST_FLUSH;
                        s_ready_nxt   = 1'b0;
                        flush_cnt_nxt = '0;
                        if (!s_last) begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FL_W'(RST_CYCLES - 1)) begin
                    state_nxt    = ST_RUN;
                    core_rst_nxt = 1'b0;
                    core_enb_nxt = 1'b1;
                end else begin
                    flush_cnt_nxt = flush_cnt + FL_W'(1);
                end
            end
            ST_RUN: begin
                cycle_count_nxt = cycle_inc;
                if (stop || ((limit_q != '0) && (cycle_inc == limit_q))) begin
                    state_nxt    = ST_DONE;
                    core_enb_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed/randomized bench for imem_boot_ctrl; expectations come from a transaction-level
// model of the load stream, flush delay and run length.
module tb_imem_boot_ctrl;

    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst, start, stop, s_valid, s_ready, s_last;
    logic [15:0]       run_limit;
    logic [31:0]       s_data, inst_data;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_wen, core_rst, core_enb, busy, done, err_overflow;
    logic [7:0]        word_count;
    logic [15:0]       cycle_count;

    int          tests = 0;
    int          fails = 0;
    bit          exp_ovf;
    logic [31:0] prog[$];

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .run_limit(run_limit),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .inst_data(inst_data), .inst_addr(inst_addr), .inst_wen(inst_wen),
        .core_rst(core_rst), .core_enb(core_enb), .busy(busy), .done(done),
        .err_overflow(err_overflow), .word_count(word_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_ovf = 1'b0;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_inst_wen", 32'(inst_wen), 32'd0);
        chk("rst_inst_addr", 32'(inst_addr), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_core_enb", 32'(core_enb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    endtask

    task automatic do_start(input logic [15:0] lim);
        run_limit = lim;
        start = 1'b1;
        step();
        start = 1'b0;
        run_limit = 16'($urandom);
        exp_ovf = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_s_ready", 32'(s_ready), 32'd1);
        chk("start_core_rst", 32'(core_rst), 32'd1);
        chk("start_core_enb", 32'(core_enb), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err_overflow), 32'd0);
        chk("start_word_count", 32'(word_count), 32'd0);
        chk("start_cycle_count", 32'(cycle_count), 32'd0);
    endtask

    // mode 0: valid always, 1: random gaps, 2: valid pattern 1,0,0,1 repeating
    task automatic do_load(input int mode, input bit use_last, input int max_beats);
        int       idx = 0;
        int       cyc = 0;
        bit       exp_ready = 1'b1;
        bit       v;
        logic [3:0] pat = 4'b1001;
        while (exp_ready && idx < max_beats && cyc < 1000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = pat[cyc % 4];
            endcase
            if (idx >= prog.size()) v = 1'b0;
            s_valid = v;
            s_data  = v ? prog[idx] : $urandom;
            s_last  = use_last && (idx == prog.size() - 1);
            chk("load_s_ready", 32'(s_ready), 32'(exp_ready));
            step();
            cyc++;
            chk("load_inst_wen", 32'(inst_wen), 32'(v));
            if (v) begin
                chk("load_inst_addr", 32'(inst_addr), 32'(idx));
                chk("load_inst_data", inst_data, prog[idx]);
                idx++;
                if (s_last || idx == DEPTH) begin
                    exp_ready = 1'b0;
                    exp_ovf   = !s_last;
                end
            end
        end
        chk("load_bounded", 32'(cyc < 1000), 32'd1);
        s_valid = (idx < prog.size());
        s_data  = s_valid ? prog[idx] : 32'd0;
        s_last  = 1'b0;
        chk("load_word_count", 32'(word_count), 32'(idx));
        chk("load_err", 32'(err_overflow), 32'(exp_ovf));
    endtask

    // core_rst must stay high for 4 cycles after the last accepted beat
    task automatic do_flush();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_core_rst", 32'(core_rst), 32'd1);
            chk("flush_core_enb", 32'(core_enb), 32'd0);
            chk("flush_s_ready", 32'(s_ready), 32'd0);
            chk("flush_inst_wen", 32'(inst_wen), 32'd0);
            chk("flush_busy", 32'(busy), 32'd1);
        end
        step();
        chk("run_core_rst", 32'(core_rst), 32'd0);
        chk("run_core_enb", 32'(core_enb), 32'd1);
        chk("run_inst_wen", 32'(inst_wen), 32'd0);
        s_valid = 1'b0;
    endtask

    task automatic do_run(input logic [15:0] lim, input int stop_at, input bit poke_start);
        int cnt = 0;
        int exp_len;
        int lim_i = int'(lim);
        if (lim_i == 0)                          exp_len = stop_at;
        else if (stop_at == 0 || stop_at > lim_i) exp_len = lim_i;
        else                                     exp_len = stop_at;
        while (core_enb === 1'b1 && cnt < 5000) begin
            cnt++;
            chk("run_cycle_count", 32'(cycle_count), 32'(cnt - 1));
            chk("run_core_rst_low", 32'(core_rst), 32'd0);
            stop  = (cnt == stop_at);
            start = poke_start && ($urandom_range(0, 3) == 0);
            step();
            stop  = 1'b0;
            start = 1'b0;
        end
        chk("run_length", 32'(cnt), 32'(exp_len));
        chk("done_flag", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_cycle_count", 32'(cycle_count), 32'(exp_len));
        chk("done_core_rst", 32'(core_rst), 32'd0);
        chk("done_core_enb", 32'(core_enb), 32'd0);
        chk("done_err", 32'(err_overflow), 32'(exp_ovf));
        step();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_cc_hold", 32'(cycle_count), 32'(exp_len));
        chk("done_enb_hold", 32'(core_enb), 32'd0);
    endtask

    initial begin
        logic [15:0] lim;
        int          sa;
        int          n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; run_limit = '0;

        do_reset();

        prog = {32'h00500093, 32'h00308113, 32'h002081B3};
        do_start(16'd10);
        do_load(0, 1'b1, 1000);
        do_flush();
        do_run(16'd10, 0, 1'b0);

        // restart from DONE, gapped stream, unlimited run stopped at cycle 25
        prog = {$urandom, $urandom};
        do_start(16'd0);
        do_load(2, 1'b1, 1000);
        do_flush();
        do_run(16'd0, 25, 1'b1);

        // overflow: 130 words, no s_last
        prog.delete();
        for (int i = 0; i < 130; i++) prog.push_back($urandom);
        do_start(16'd5);
        do_load(0, 1'b0, 1000);
        chk("ovf_word_count", 32'(word_count), 32'd128);
        do_flush();
        do_run(16'd5, 0, 1'b0);

        // randomized programs, limits and stops (last pass: stop and limit coincide)
        for (int k = 0; k < 4; k++) begin
            n   = $urandom_range(1, 20);
            lim = 16'($urandom_range(1, 30));
            sa  = (k == 3) ? int'(lim) : $urandom_range(0, 40);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            do_start(lim);
            do_load(1, 1'b1, 1000);
            do_flush();
            do_run(lim, sa, 1'b1);
        end

        // reset in the middle of a load
        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back($urandom);
        do_start(16'd0);
        do_load(0, 1'b0, 5);
        chk("midload_wc", 32'(word_count), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_inst_wen", 32'(inst_wen), 32'd0);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
